// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full-adder cell.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one full-adder cell per cycle, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit so the counter can reach WIDTH on the last edge without wrapping.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_co;

  fa_bit u_fa (
    .x (a_q[0]),
    .y (b_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            cout_q  <= fa_co;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Called away from a clock edge with the DUT idle; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom_range(0, 1));
  endtask

  // n = index of the cycle (after the start edge) in which done is seen; bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
      a = W'($urandom);
      b = W'($urandom);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h required all 0",
               busy, done, cout, sum);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_idle got busy=%b done=%b required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_basic;
    int n;
    logic [W:0] exp;
    exp = model(8'h5A, 8'h3C, 1'b0);
    launch(8'h5A, 8'h3C, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL basic_run_flags got busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n != W + 1) begin
      failures++;
      $display("FAIL basic_latency got %0d required %0d", n, W + 1);
    end
    checks++;
    if ({cout, sum} !== 9'h096 || {cout, sum} !== exp) begin
      failures++;
      $display("FAIL basic_result got %h required %h", {cout, sum}, exp);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_in_done got %b required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
      failures++;
      $display("FAIL basic_after_done got done=%b busy=%b res=%h required 0 0 %h",
               done, busy, {cout, sum}, exp);
    end
  endtask

  task automatic test_boundary;
    logic [W-1:0] ta [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] tb [3] = '{8'h01, 8'hFF, 8'h00};
    logic         tc [3] = '{1'b0, 1'b1, 1'b1};
    logic [W:0]   req[3] = '{9'h100, 9'h1FF, 9'h001};
    int n;
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(n);
      checks++;
      if ({cout, sum} !== req[i] || {cout, sum} !== model(ta[i], tb[i], tc[i])) begin
        failures++;
        $display("FAIL boundary_%0d got %h required %h", i, {cout, sum}, req[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    int base;
    logic [W:0] exp;
    base = done_pulses;
    exp  = model(8'h21, 8'h43, 1'b1);
    launch(8'h21, 8'h43, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hEE; b = 8'hDD; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1; a = 8'h99; b = 8'h77; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_in_done got busy=%b done=%b required 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_pulses - base != 1) begin
      failures++;
      $display("FAIL ignore_done_count got %0d required 1", done_pulses - base);
    end
    checks++;
    if ({cout, sum} !== exp || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got %h busy=%b required %h 0", {cout, sum}, busy, exp);
    end
  endtask

  task automatic test_async_reset;
    int n;
    int base;
    base = done_pulses;
    launch(8'hFF, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%b done=%b cout=%b sum=%h required all 0",
               busy, done, cout, sum);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_pulses != base) begin
      failures++;
      $display("FAIL async_reset_no_done got %0d pulses required 0", done_pulses - base);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL async_release_idle got busy=%b required 0", busy);
    end
    launch(8'h01, 8'h02, 1'b0);
    wait_done(n);
    checks++;
    if (n != W + 1 || {cout, sum} !== 9'h003) begin
      failures++;
      $display("FAIL async_after_reset got lat=%0d res=%h required %0d 003",
               n, {cout, sum}, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int last;
    int pulses;
    int n;
    logic [W:0] exp;
    exp = model(8'h12, 8'h34, 1'b1);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        checks++;
        if ({cout, sum} !== exp) begin
          failures++;
          $display("FAIL b2b_result got %h required %h", {cout, sum}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (i - last != W + 2) begin
            failures++;
            $display("FAIL b2b_period got %0d required %0d", i - last, W + 2);
          end
        end
        last = i;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 5) begin
      failures++;
      $display("FAIL b2b_pulses got %0d required 5", pulses);
    end
    n = 0;
    while (busy !== 1'b0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got busy=%b required 0", busy);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] av, bv;
    logic         cv;
    logic [W:0]   exp;
    int n;
    for (int k = 0; k < 1000; k++) begin
      av  = W'($urandom);
      bv  = W'($urandom);
      cv  = 1'($urandom_range(0, 1));
      exp = model(av, bv, cv);
      launch(av, bv, cv);
      wait_done(n);
      checks++;
      if (n != W + 1 || {cout, sum} !== exp) begin
        failures++;
        $display("FAIL random_%0d got lat=%0d res=%h required %0d %h",
                 k, n, {cout, sum}, W + 1, exp);
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        @(negedge clk);
        checks++;
        if ({cout, sum} !== exp || done !== 1'b0) begin
          failures++;
          $display("FAIL random_hold_%0d got res=%h done=%b required %h 0",
                   k, {cout, sum}, done, exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, the request to begin an addition; sampled only when busy=0.
REQ-005 The block SHALL have port a, input, WIDTH, operand A; captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH, operand B; captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1, the carry-in; captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in RUN or DONE.
REQ-009 The block SHALL have port done, output, 1, a single-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port sum, output, WIDTH, the result; held stable from done until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1, the carry-out; held with sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using one 1-bit full-adder cell per cycle.
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE; reset state IDLE.
REQ-014 IDLE->RUN SHALL occur on a clock edge with start=1; that edge SHALL load the A/B shift registers, load the carry flop with cin, clear bit counter cnt to 0, and clear sum/cout.
REQ-015 In RUN, each edge SHALL shift the cell sum bit into sum from the MSB side, right-shift A/B, store the cell carry into the carry flop, and increment cnt.
REQ-016 RUN->DONE SHALL occur on the edge where cnt=WIDTH-1; that edge SHALL load the final carry into cout.
REQ-017 DONE SHALL last exactly one cycle with done=1, then move to IDLE.
REQ-018 Latency SHALL be: start sampled at edge k, RUN during cycles k+1..k+WIDTH, done=1 in cycle k+WIDTH+1, and the next start accepted at edge k+WIDTH+2.
REQ-019 start SHALL be ignored while busy=1, including in DONE; operands and result are unaffected.
REQ-020 done SHALL never be high in IDLE or RUN; busy SHALL be low only in IDLE.
REQ-021 Counter arithmetic SHALL use width $clog2(WIDTH)+1 with no wrap-around; the carry out of the MSB SHALL go only to cout (no truncation of the carry).
REQ-022 Operand inputs SHALL not be sampled outside the accepting edge; changes during RUN SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, carry flop=0 and the shift registers to 0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-025 Release of rst_n SHALL take effect only at a clock edge; no operation SHALL start on the release edge unless start=1 at that edge.

Structure
REQ-026 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The 1-bit adder SHALL be a single combinational sub-module fa_bit (inputs x, y, ci; outputs s, co); all sequencing stays in serial_add_ctrl.

Verification (WIDTH=8)
REQ-028 Scenario 1: start with a=0x5A, b=0x3C, cin=0 -> done exactly 9 cycles after the start edge, sum=0x96, cout=0.
REQ-029 Scenario 2: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 Scenario 3: start pulsed again at RUN cycle 3 and in DONE, with different operands -> ignored; result is that of the first operands and exactly one done pulse is produced.
REQ-031 Scenario 4: rst_n=0 at RUN cycle 4 -> outputs 0 immediately (asynchronous), no done pulse; a subsequent a=0x01, b=0x02 gives sum=0x03.
REQ-032 Scenario 5: start held high continuously -> operations back-to-back, one every 10 cycles, each with a one-cycle done pulse.
REQ-033 Scenario 6: 1000 random a/b/cin vectors checked against a+b+cin, with sum/cout stable from done until the next accepted start.
